hub75_scanner: RTL and testbench

//   Downstream consumer of the sync_pdp_ram frame buffer. Scans the buffer row by
//   row through the RAM read port and drives a 64x32, 1/16-scan HUB75 panel.
//   Per row: shift one row of pixel pairs, blank, latch, display for ON_TIME.
//   One byte holds two pixels: one in the top half and one in the bottom half.

---
 rtl/hub75_scanner.sv | 159 +++++++++++++++
 tb/tb_hub75_scanner.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scanner.sv
// Reads a frame buffer through a 1-cycle-latency RAM port and drives a 1/16-scan HUB75
// panel: shift one row of pixel pairs, blank, latch, then display for ON_TIME cycles.
module hub75_scanner #(
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 4,
  parameter int ON_TIME  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic [COL_BITS+ROW_BITS-1:0] read_addr,
  output logic                         read_en,
  input  logic [7:0]                   read_data,
  output logic [2:0]                   rgb1,
  output logic [2:0]                   rgb2,
  output logic                         hub75_clk,
  output logic                         latch,
  output logic                         oe_n,
  output logic [ROW_BITS-1:0]          row_addr,
  output logic                         frame_start
);

  localparam int                  ADDR_BITS = COL_BITS + ROW_BITS;
  localparam logic [COL_BITS-1:0] LAST_COL  = '1;
  localparam logic [ROW_BITS-1:0] LAST_ROW  = '1;
  localparam logic [15:0]         ON_LOAD   = 16'(ON_TIME - 1);

  typedef enum logic [2:0] {
    IDLE, READ, SETUP, CLOCK, BLANK, LATCH, UNLATCH, DISPLAY
  } state_t;

  state_t                 state_q, state_d;
  logic [COL_BITS-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0]    row_q, row_d;
  logic [15:0]            on_cnt_q, on_cnt_d;

  logic [ADDR_BITS-1:0]   read_addr_q, read_addr_d;
  logic                   read_en_q, read_en_d;
  logic [2:0]             rgb1_q, rgb1_d;
  logic [2:0]             rgb2_q, rgb2_d;
  logic                   hub75_clk_q, hub75_clk_d;
  logic                   latch_q, latch_d;
  logic                   oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0]    row_addr_q, row_addr_d;
  logic                   frame_start_q, frame_start_d;

  // Each RAM byte packs the top-half pixel in [2:0] and the bottom-half pixel in [5:3].
  logic [2:0] pixel_field [2];
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_field
      assign pixel_field[gi] = read_data[3*gi +: 3];
    end
  endgenerate

  logic unused_data_bits;
  assign unused_data_bits = ^read_data[7:6];

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    on_cnt_d      = on_cnt_q;
    rgb1_d        = rgb1_q;
    rgb2_d        = rgb2_q;
    frame_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          col_d   = '0;
          state_d = READ;
        end
      end
      READ:  state_d = SETUP;
      SETUP: begin
        rgb1_d  = pixel_field[0];
        rgb2_d  = pixel_field[1];
        state_d = CLOCK;
      end
      CLOCK: begin
        if (col_q == LAST_COL) begin
          state_d = BLANK;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = READ;
        end
      end
      BLANK: state_d = LATCH;
      LATCH: state_d = UNLATCH;
      UNLATCH: begin
        on_cnt_d = ON_LOAD;
        state_d  = DISPLAY;
      end
      DISPLAY: begin
        if (on_cnt_q == '0) begin
          col_d         = '0;
          row_d         = row_q + 1'b1;
          frame_start_d = (row_q == LAST_ROW);
          state_d       = enable ? READ : IDLE;
        end else begin
          on_cnt_d = on_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered off the next state so they line up with the state they belong to.
    read_en_d   = (state_d == READ);
    read_addr_d = (state_d == READ) ? {row_d, col_d} : read_addr_q;
    hub75_clk_d = (state_d == CLOCK);
    latch_d     = (state_d == LATCH);
    oe_n_d      = (state_d != DISPLAY);
    row_addr_d  = (state_d == LATCH) ? row_q : row_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      on_cnt_q      <= '0;
      read_addr_q   <= '0;
      read_en_q     <= 1'b0;
      rgb1_q        <= '0;
      rgb2_q        <= '0;
      hub75_clk_q   <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      row_addr_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      on_cnt_q      <= on_cnt_d;
      read_addr_q   <= read_addr_d;
      read_en_q     <= read_en_d;
      rgb1_q        <= rgb1_d;
      rgb2_q        <= rgb2_d;
      hub75_clk_q   <= hub75_clk_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      row_addr_q    <= row_addr_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign read_addr   = read_addr_q;
  assign read_en     = read_en_q;
  assign rgb1        = rgb1_q;
  assign rgb2        = rgb2_q;
  assign hub75_clk   = hub75_clk_q;
  assign latch       = latch_q;
  assign oe_n        = oe_n_q;
  assign row_addr    = row_addr_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scanner.sv
// Bench for hub75_scanner: two instances (ON_TIME 64 and 1) against a row-phase timing model.
module tb_hub75_scanner;

  localparam int COLS = 64;
  localparam int ROWS = 16;
  localparam int ON0  = 64;
  localparam int ON1  = 1;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #5 clk = ~clk;

  logic [7:0] mem [1024];

  logic       ren0, hclk0, latch0, oen0, fs0;
  logic [9:0] raddr0;
  logic [7:0] rdata0;
  logic [2:0] rgb1_0, rgb2_0;
  logic [3:0] rowa0;
  logic       ren1, hclk1, latch1, oen1, fs1;
  logic [9:0] raddr1;
  logic [7:0] rdata1;
  logic [2:0] rgb1_1, rgb2_1;
  logic [3:0] rowa1;

  hub75_scanner #(.COL_BITS(6), .ROW_BITS(4), .ON_TIME(ON0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .read_addr(raddr0), .read_en(ren0), .read_data(rdata0),
    .rgb1(rgb1_0), .rgb2(rgb2_0), .hub75_clk(hclk0), .latch(latch0),
    .oe_n(oen0), .row_addr(rowa0), .frame_start(fs0)
  );

  hub75_scanner #(.COL_BITS(6), .ROW_BITS(4), .ON_TIME(ON1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .read_addr(raddr1), .read_en(ren1), .read_data(rdata1),
    .rgb1(rgb1_1), .rgb2(rgb2_1), .hub75_clk(hclk1), .latch(latch1),
    .oe_n(oen1), .row_addr(rowa1), .frame_start(fs1)
  );

  always @(posedge clk) if (ren0) rdata0 <= mem[raddr0];
  always @(posedge clk) if (ren1) rdata1 <= mem[raddr1];

  logic [24:0] bund [2];
  logic        latch_w [2];
  logic        oen_w [2];
  logic        fs_w [2];
  logic [3:0]  rowa_w [2];
  assign bund[0] = {ren0, raddr0, rgb1_0, rgb2_0, hclk0, latch0, oen0, rowa0, fs0};
  assign bund[1] = {ren1, raddr1, rgb1_1, rgb2_1, hclk1, latch1, oen1, rowa1, fs1};
  assign latch_w[0] = latch0;
  assign latch_w[1] = latch1;
  assign oen_w[0]   = oen0;
  assign oen_w[1]   = oen1;
  assign fs_w[0]    = fs0;
  assign fs_w[1]    = fs1;
  assign rowa_w[0]  = rowa0;
  assign rowa_w[1]  = rowa1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: each row is a fixed timeline of phases; phase t < 3*COLS walks column t/3
  // through read / setup / shift, then blank, latch, unlatch and ON_TIME display cycles.
  bit         m_valid = 0;
  bit         m_active [2];
  int         m_row [2];
  int         m_phase [2];
  logic [9:0] m_raddr [2];
  logic [2:0] m_rgb1 [2];
  logic [2:0] m_rgb2 [2];
  logic [3:0] m_rowaddr [2];
  bit         m_frame [2];

  function automatic int row_period(input int k);
    return 3 * COLS + 3 + ((k == 0) ? ON0 : ON1);
  endfunction

  task automatic model_step(input int k, input bit rst, input bit en);
    bit fr;
    int t;
    int addr;
    fr = 0;
    if (rst) begin
      m_active[k] = 0; m_row[k] = 0; m_phase[k] = 0;
      m_raddr[k] = '0; m_rgb1[k] = '0; m_rgb2[k] = '0; m_rowaddr[k] = '0;
    end else if (!m_active[k]) begin
      if (en) begin
        m_active[k] = 1;
        m_phase[k]  = 0;
      end
    end else begin
      m_phase[k]++;
      if (m_phase[k] == row_period(k)) begin
        fr          = (m_row[k] == ROWS - 1);
        m_row[k]    = (m_row[k] + 1) % ROWS;
        m_phase[k]  = 0;
        m_active[k] = en;
      end
    end
    m_frame[k] = fr;
    if (m_active[k]) begin
      t = m_phase[k];
      if (t < 3 * COLS) begin
        addr = m_row[k] * COLS + t / 3;
        if (t % 3 == 0) m_raddr[k] = 10'(addr);
        if (t % 3 == 2) begin
          m_rgb1[k] = mem[addr][2:0];
          m_rgb2[k] = mem[addr][5:3];
        end
      end else if (t == 3 * COLS + 1) begin
        m_rowaddr[k] = 4'(m_row[k]);
      end
    end
  endtask

  function automatic logic [24:0] exp_bundle(input int k);
    int t;
    bit rd, hc, la, dis;
    t   = m_phase[k];
    rd  = m_active[k] && (t < 3 * COLS) && (t % 3 == 0);
    hc  = m_active[k] && (t < 3 * COLS) && (t % 3 == 2);
    la  = m_active[k] && (t == 3 * COLS + 1);
    dis = m_active[k] && (t >= 3 * COLS + 3);
    return {rd, m_raddr[k], m_rgb1[k], m_rgb2[k], hc, la, ~dis, m_rowaddr[k], m_frame[k]};
  endfunction

  initial begin : compare
    bit rst_s, en_s;
    forever begin
      @(posedge clk);
      rst_s = reset;
      en_s  = enable;
      cyc++;
      for (int k = 0; k < 2; k++) model_step(k, rst_s, en_s);
      if (rst_s) m_valid = 1;
      #1;
      if (m_valid) begin
        for (int k = 0; k < 2; k++)
          check($sformatf("dut%0d_outputs@%0d", k, cyc), 32'(bund[k]), 32'(exp_bundle(k)));
        if (latch0) $display("[TB] dut0 latched row %0d at cycle %0d", rowa0, cyc);
      end
    end
  end

  task automatic wait_latch(input int k, input int limit, output int at, output bit ok);
    ok = 0; at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (latch_w[k]) begin ok = 1; at = cyc; break; end
    end
  endtask

  task automatic wait_frame(input int k, input int limit, output int at, output bit ok);
    ok = 0; at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (fs_w[k]) begin ok = 1; at = cyc; break; end
    end
  endtask

  task automatic latch_period(input int k, input int exp_p, input int exp_on);
    int t0;
    int lows;
    bit ok;
    wait_latch(k, 600, t0, ok);
    if (ok) begin
      lows = 0; ok = 0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        if (!oen_w[k]) lows++;
        if (latch_w[k]) begin
          ok = 1;
          check($sformatf("dut%0d_latch_period", k), 32'(cyc - t0), 32'(exp_p));
          check($sformatf("dut%0d_oe_low_cycles", k), 32'(lows), 32'(exp_on));
          break;
        end
      end
    end
    if (!ok) check($sformatf("dut%0d_latch_timeout", k), 0, 1);
  endtask

  task automatic frame_period(input int k, input int exp_p);
    int t0, t1;
    bit ok;
    wait_frame(k, 5000, t0, ok);
    if (ok) begin
      check($sformatf("dut%0d_row_addr_at_frame_start", k), 32'(rowa_w[k]), 15);
      wait_frame(k, exp_p + 10, t1, ok);
      if (ok) check($sformatf("dut%0d_frame_period", k), 32'(t1 - t0), 32'(exp_p));
    end
    if (!ok) check($sformatf("dut%0d_frame_timeout", k), 0, 1);
  endtask

  initial begin : stim
    int  t0, at, lows, rst_left;
    bit  ok;
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_read_en", 32'(ren0), 1);
    check("first_read_addr", 32'(raddr0), 0);
    check("first_read_addr_dut1", 32'(raddr1), 0);

    latch_period(0, 259, 64);
    latch_period(1, 196, 1);
    frame_period(0, 4144);
    frame_period(1, 3136);

    // Drop enable at row 5, column 10 of dut0; the row must still finish.
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_active[0] && m_row[0] == 5 && m_phase[0] == 30) begin ok = 1; break; end
    end
    check("reach_row5_col10", 32'(ok), 1);
    enable = 1'b0;
    ok = 0; lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!oen0) lows++;
      if (!m_active[0]) begin ok = 1; break; end
    end
    check("row5_completes", 32'(ok), 1);
    check("row5_display_cycles", 32'(lows), 64);
    check("idle_oe_n", 32'(oen0), 1);
    check("idle_read_en", 32'(ren0), 0);
    check("idle_row_addr", 32'(rowa0), 5);
    $display("[TB] dut0 idle after row 5 at cycle %0d", cyc);
    repeat (20) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("resume_read_en", 32'(ren0), 1);
    check("resume_read_addr", 32'(raddr0), 384);

    // Random enable toggles and short resets, checked cycle by cycle against the model.
    rst_left = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (reset) begin
        if (rst_left == 0) reset = 1'b0;
        else rst_left--;
      end else if ($urandom_range(0, 1999) == 0) begin
        reset = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else if ($urandom_range(0, 149) == 0) begin
        enable = ~enable;
      end
    end
    reset = 1'b0;
    enable = 1'b1;

    // Reset in the middle of row 9's display.
    ok = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (m_active[0] && m_row[0] == 9 && m_phase[0] == 3 * COLS + 3 + 20) begin ok = 1; break; end
    end
    check("reach_row9_display", 32'(ok), 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_outputs_dut0", 32'(bund[0]), 32'h20);
    check("reset_outputs_dut1", 32'(bund[1]), 32'h20);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("restart_read_en", 32'(ren0), 1);
    check("restart_read_addr", 32'(raddr0), 0);
    t0 = cyc;
    wait_latch(0, 400, at, ok);
    check("first_latch_after_reset", ok ? 32'(at - t0) : 32'hFFFF_FFFF, 193);
    check("first_latch_row_after_reset", 32'(rowa0), 0);
    repeat (50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
